mutex_requester: RTL and testbench



---
 rtl/mutex_pkg.sv | 19 +
 rtl/sat_counter.sv | 36 +++
 rtl/mutex_requester.sv | 197 +++++++++++++++++++
 tb/tb_mutex_requester.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_pkg.sv
// Shared types and defaults for the mutex requester block and its helpers.
package mutex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    localparam int unsigned LEN_W_DEFAULT    = 8;
    localparam int unsigned HOLD_MAX_DEFAULT = 256;
    localparam int unsigned GAP_DEFAULT      = 2;

    localparam int unsigned WAIT_CNT_W  = 16;
    localparam int unsigned ABORT_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mutex_requester.sv
// Client side of the priority-arbiter mutex: request, burst, release, idle gap.
// Defining MUTEX_REQUESTER_STATS_EN adds WaitCycles and AbortCount outputs.
module mutex_requester
    import mutex_pkg::*;
#(
    parameter int unsigned LEN_W    = LEN_W_DEFAULT,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int unsigned GAP      = GAP_DEFAULT
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Start,
    input  logic [LEN_W-1:0] Length,
    output logic             Busy,
    output logic             Done,
    output logic             Aborted,
    output logic             Request,
    input  logic             Grant,
    output logic             Valid,
    input  logic             Ready
`ifdef MUTEX_REQUESTER_STATS_EN
    ,
    output logic [WAIT_CNT_W-1:0]  WaitCycles,
    output logic [ABORT_CNT_W-1:0] AbortCount
`endif
);

    localparam int unsigned HOLD_W = $clog2(HOLD_MAX);
    localparam int unsigned GAP_W  = $clog2(GAP + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    state_e            state_q,      state_d;
    logic              request_q,    request_d;
    logic              valid_q,      valid_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              aborted_q,    aborted_d;
    logic              abort_flag_q, abort_flag_d;
    logic [LEN_W-1:0]  remaining_q,  remaining_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,    gap_cnt_d;

    logic accept;

    assign accept = valid_q && Ready;

    always_comb begin
        state_d      = state_q;
        request_d    = request_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        abort_flag_d = abort_flag_q;
        remaining_d  = remaining_q;
        hold_cnt_d   = hold_cnt_q;
        gap_cnt_d    = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Length != '0) begin
                        remaining_d = Length;
                        request_d   = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_REQUEST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_REQUEST: begin
                if (Grant) begin
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                // A lost grant discards this cycle's handshake; a timeout still counts it.
                if (!Grant) begin
                    valid_d      = 1'b0;
                    request_d    = 1'b0;
                    abort_flag_d = 1'b1;
                    state_d      = ST_RELEASE;
                end else if (accept && (remaining_q == LEN_ONE)) begin
                    remaining_d = remaining_q - 1'b1;
                    valid_d     = 1'b0;
                    request_d   = 1'b0;
                    state_d     = ST_RELEASE;
                end else begin
                    if (accept) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    if (hold_cnt_q == HOLD_LAST) begin
                        valid_d      = 1'b0;
                        request_d    = 1'b0;
                        abort_flag_d = 1'b1;
                        state_d      = ST_RELEASE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                if (!Grant) begin
                    done_d    = 1'b1;
                    aborted_d = abort_flag_q;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GAP_W'(1)) begin
                    busy_d       = 1'b0;
                    abort_flag_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            request_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_flag_q <= 1'b0;
            remaining_q  <= '0;
            hold_cnt_q   <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            request_q    <= request_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_flag_q <= abort_flag_d;
            remaining_q  <= remaining_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign Request = request_q;
    assign Valid   = valid_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Aborted = aborted_q;

`ifdef MUTEX_REQUESTER_STATS_EN
    logic wait_clr;
    logic wait_en;

    assign wait_clr = (state_q == ST_IDLE) && (state_d == ST_REQUEST);
    assign wait_en  = (state_q == ST_REQUEST);

    sat_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk     (Clk),
        .rst_n   (nReset),
        .clr_i   (wait_clr),
        .en_i    (wait_en),
        .count_o (WaitCycles)
    );

    sat_counter #(
        .WIDTH (ABORT_CNT_W)
    ) u_abort_cnt (
        .clk     (Clk),
        .rst_n   (nReset),
        .clr_i   (1'b0),
        .en_i    (aborted_d),
        .count_o (AbortCount)
    );
`else
    // Without statistics the handshake FSM above is the complete block.
`endif

endmodule

// File: tb/tb_mutex_requester.sv
// Two mutex requesters on a registered 2-bit priority arbiter model with grant hold.
module tb_mutex_requester;

    localparam int LEN_W    = 8;
    localparam int HOLD_MAX = 8;
    localparam int GAP      = 2;
    localparam int N        = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]     start;
    logic [N-1:0]     busy;
    logic [N-1:0]     done;
    logic [N-1:0]     aborted;
    logic [N-1:0]     request;
    logic [N-1:0]     grant;
    logic [N-1:0]     valid;
    logic [N-1:0]     ready;
    logic [N-1:0]     kill;
    logic [N-1:0]     arb_q;
    logic [LEN_W-1:0] length [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_req
`ifdef MUTEX_REQUESTER_STATS_EN
        logic [15:0] wait_cycles;
        logic [7:0]  abort_count;
`endif
        mutex_requester #(
            .LEN_W    (LEN_W),
            .HOLD_MAX (HOLD_MAX),
            .GAP      (GAP)
        ) u_dut (
            .Clk     (clk),
            .nReset  (rst_n),
            .Start   (start[g]),
            .Length  (length[g]),
            .Busy    (busy[g]),
            .Done    (done[g]),
            .Aborted (aborted[g]),
            .Request (request[g]),
            .Grant   (grant[g]),
            .Valid   (valid[g]),
            .Ready   (ready[g])
`ifdef MUTEX_REQUESTER_STATS_EN
            ,
            .WaitCycles (wait_cycles),
            .AbortCount (abort_count)
`endif
        );
    end

    // Owner keeps the grant while it requests; otherwise lowest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_q <= '0;
        end else if ((arb_q & request) != '0) begin
            arb_q <= arb_q;
        end else if (request[0]) begin
            arb_q <= 2'b01;
        end else if (request[1]) begin
            arb_q <= 2'b10;
        end else begin
            arb_q <= '0;
        end
    end

    assign grant = arb_q & ~kill;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int          len;
        logic [15:0] pat;
        int          vcyc;
        int          acc;
        int          ab;
        int          done_t;
        int          busy_gap;
        int          req;
        int          first_v;
    } vec_t;

    vec_t vecs [8];

    // Single burst on instance 0; pat bit k is Ready on the k-th Valid cycle.
    task automatic run_burst(input int len, input logic [15:0] pat,
                             output int vcyc, output int acc, output int ab,
                             output int done_t, output int busy_gap, output int req_seen,
                             output int done_cnt, output int first_v);
        int vidx;
        bit finished;
        vcyc = 0; acc = 0; ab = 0; done_t = -1; busy_gap = -1;
        req_seen = 0; done_cnt = 0; first_v = -1; vidx = 0; finished = 0;
        @(negedge clk);
        start[0]  = 1'b1;
        length[0] = LEN_W'(len);
        ready[0]  = 1'b0;
        for (int t = 1; t <= 200 && !finished; t++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (request[0]) req_seen = 1;
            if (done[0]) begin
                done_cnt++;
                done_t = t;
                ab     = int'(aborted[0]);
            end
            if (done_t >= 0 && busy_gap < 0 && !busy[0]) busy_gap = t - done_t;
            if (valid[0]) begin
                vcyc++;
                if (first_v < 0) first_v = t;
                ready[0] = (vidx < 16) ? pat[vidx] : 1'b0;
                acc += int'(ready[0]);
                vidx++;
            end else begin
                ready[0] = 1'b0;
            end
            if (busy_gap >= 0 && t >= done_t + 4) finished = 1;
        end
        check("burst_completes", int'(finished), 1);
    endtask

    int ph [N];
    int mlen [N];
    int mn [N];
    int macc [N];
    int budget [N];

    // Burst-level scoreboard: a burst ends when Length transfers are accepted
    // or HOLD_MAX Valid cycles have elapsed, whichever comes first.
    task automatic rnd_cycle(input bit allow_start);
        @(negedge clk);
        check("rnd_mutex", int'(valid[0] & valid[1]), 0);
        for (int i = 0; i < N; i++) begin
            logic r;
            start[i] = 1'b0;
            r = ($urandom_range(0, 3) != 0);
            case (ph[i])
                0: begin
                    check("rnd_idle_valid", int'(valid[i]), 0);
                    check("rnd_idle_done", int'(done[i]), 0);
                end
                1: begin
                    check("rnd_wait_done", int'(done[i]), 0);
                    if (valid[i]) ph[i] = 2;
                end
                2: begin
                    check("rnd_valid_held", int'(valid[i]), 1);
                    check("rnd_active_done", int'(done[i]), 0);
                end
                3: begin
                    check("rnd_valid_drop", int'(valid[i]), 0);
                    if (done[i]) begin
                        check("rnd_aborted", int'(aborted[i]), int'(macc[i] < mlen[i]));
                        ph[i] = 0;
                    end
                end
                default: begin
                    check("rnd_len0_done", int'(done[i]), 1);
                    check("rnd_len0_abort", int'(aborted[i]), 0);
                    check("rnd_len0_req", int'(request[i]), 0);
                    ph[i] = 0;
                end
            endcase
            if (ph[i] == 2) begin
                mn[i]++;
                macc[i] += int'(r);
                if (macc[i] == mlen[i] || mn[i] == HOLD_MAX) ph[i] = 3;
            end
            ready[i] = r;
            if (ph[i] != 0) begin
                budget[i]--;
                if (budget[i] <= 0) begin
                    check("rnd_budget", ph[i], 0);
                    ph[i] = 0;
                end
            end
            if (allow_start && !busy[i] && ph[i] == 0 && $urandom_range(0, 3) == 0) begin
                int len;
                len       = int'($urandom_range(0, 11));
                start[i]  = 1'b1;
                length[i] = LEN_W'(len);
                mlen[i]   = len;
                mn[i]     = 0;
                macc[i]   = 0;
                budget[i] = 300;
                ph[i]     = (len == 0) ? 4 : 1;
            end else if (allow_start && busy[i] && $urandom_range(0, 7) == 0) begin
                start[i]  = 1'b1;
                length[i] = LEN_W'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vcyc, acc, ab, done_t, busy_gap, req_seen, done_cnt, first_v;

        vecs[0] = '{4,  16'hFFFF, 4, 4, 0,  9, 2, 1,  3};
        vecs[1] = '{3,  16'h0029, 6, 3, 0, 11, 2, 1,  3};
        vecs[2] = '{20, 16'h0000, 8, 0, 1, 13, 2, 1,  3};
        vecs[3] = '{1,  16'hFFFF, 1, 1, 0,  6, 2, 1,  3};
        vecs[4] = '{8,  16'hFFFF, 8, 8, 0, 13, 2, 1,  3};
        vecs[5] = '{9,  16'hFFFF, 8, 8, 1, 13, 2, 1,  3};
        vecs[6] = '{0,  16'hFFFF, 0, 0, 0,  1, 0, 0, -1};
        vecs[7] = '{5,  16'h0076, 7, 5, 0, 12, 2, 1,  3};

        start = '0; ready = '0; kill = '0;
        length[0] = '0; length[1] = '0;
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; mlen[i] = 0; mn[i] = 0; macc[i] = 0; budget[i] = 0;
        end

        #1;
        check("reset_request", int'(request), 0);
        check("reset_valid",   int'(valid),   0);
        check("reset_busy",    int'(busy),    0);
        check("reset_done",    int'(done),    0);
        check("reset_aborted", int'(aborted), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i].len, vecs[i].pat, vcyc, acc, ab, done_t, busy_gap,
                      req_seen, done_cnt, first_v);
            check($sformatf("v%0d_valid_cycles", i), vcyc, vecs[i].vcyc);
            check($sformatf("v%0d_accepted", i), acc, vecs[i].acc);
            check($sformatf("v%0d_aborted", i), ab, vecs[i].ab);
            check($sformatf("v%0d_done_time", i), done_t, vecs[i].done_t);
            check($sformatf("v%0d_busy_gap", i), busy_gap, vecs[i].busy_gap);
            check($sformatf("v%0d_request_seen", i), req_seen, vecs[i].req);
            check($sformatf("v%0d_first_valid", i), first_v, vecs[i].first_v);
            check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
        end

        begin : grant_loss
            int gl_v4, gl_v5, gl_r5, gl_done_t, gl_ab, gl_after;
            gl_v4 = 0; gl_v5 = 1; gl_r5 = 1; gl_done_t = -1; gl_ab = 0; gl_after = 0;
            @(negedge clk);
            start[0] = 1'b1; length[0] = LEN_W'(10); ready[0] = 1'b1;
            for (int t = 1; t <= 30; t++) begin
                @(negedge clk);
                start[0] = 1'b0;
                if (t == 4) begin
                    gl_v4   = int'(valid[0]);
                    kill[0] = 1'b1;
                end
                if (t == 5) begin
                    gl_v5 = int'(valid[0]);
                    gl_r5 = int'(request[0]);
                end
                if (t > 5 && valid[0]) gl_after++;
                if (done[0]) begin
                    gl_done_t = t;
                    gl_ab     = int'(aborted[0]);
                    kill[0]   = 1'b0;
                end
            end
            ready[0] = 1'b0;
            check("gl_active_before", gl_v4, 1);
            check("gl_valid_drop", gl_v5, 0);
            check("gl_request_drop", gl_r5, 0);
            check("gl_done_time", gl_done_t, 6);
            check("gl_aborted", gl_ab, 1);
            check("gl_no_valid_after", gl_after, 0);
        end

        begin : reset_mid_burst
            int rd, rr;
            rd = 0; rr = 0;
            @(negedge clk);
            start[0] = 1'b1; length[0] = LEN_W'(10); ready[0] = 1'b0;
            for (int t = 1; t <= 5; t++) begin
                @(negedge clk);
                start[0] = 1'b0;
            end
            check("rst_pre_valid", int'(valid[0]), 1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_request_drop", int'(request[0]), 0);
            check("rst_valid_drop", int'(valid[0]), 0);
            check("rst_busy_drop", int'(busy[0]), 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                rd += int'(done[0]);
                rr += int'(request[0]);
            end
            check("rst_no_done", rd, 0);
            check("rst_no_request", rr, 0);
        end

        begin : contention
            int v0a, v1a, v0b, overlap, restart_t, d0, d1, ab_cnt;
            logic prev_b0;
            v0a = -1; v1a = -1; v0b = -1; overlap = 0; restart_t = -1;
            d0 = 0; d1 = 0; ab_cnt = 0; prev_b0 = 1'b0;
            @(negedge clk);
            start = 2'b11; length[0] = LEN_W'(2); length[1] = LEN_W'(2); ready = 2'b11;
            for (int t = 1; t <= 60; t++) begin
                @(negedge clk);
                start = 2'b00;
                if (valid[0] && valid[1]) overlap++;
                if (valid[0]) begin
                    if (v0a < 0) v0a = t;
                    else if (restart_t >= 0 && v0b < 0) v0b = t;
                end
                if (valid[1] && v1a < 0) v1a = t;
                d0 += int'(done[0]);
                d1 += int'(done[1]);
                ab_cnt += int'(aborted[0]) + int'(aborted[1]);
                if (prev_b0 && !busy[0] && restart_t < 0) begin
                    start[0]  = 1'b1;
                    length[0] = LEN_W'(2);
                    restart_t = t;
                end
                prev_b0 = busy[0];
            end
            ready = 2'b00;
            check("ct_idx0_first", v0a, 3);
            check("ct_idx1_granted", v1a, 7);
            check("ct_idx1_before_reissue", int'(v1a > 0 && v1a < v0b), 1);
            check("ct_reissue_served", v0b, 12);
            check("ct_no_overlap", overlap, 0);
            check("ct_done0", d0, 2);
            check("ct_done1", d1, 1);
            check("ct_no_aborts", ab_cnt, 0);
        end

        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 150; c++) rnd_cycle(1'b0);
        check("rnd_drain0", ph[0], 0);
        check("rnd_drain1", ph[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
